// File: rtl/lpddr4_dly_pkg.sv
// ============================================================================
// Module   : lpddr4_dly_pkg
// Purpose  : Shared constants and helpers for the LPDDR4 programmable delay line
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lpddr4_dly_pkg;

    localparam int DLY_DEPTH_DEF = 32;

    // Selections beyond the last stage (non-power-of-2 depths) pin to the last stage
    function automatic int unsigned dly_clamp_sel(input int unsigned sel,
                                                  input int unsigned depth);
        if (sel > depth - 1) begin
            return depth - 1;
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dly_settle_ctr.sv
// ============================================================================
// Module   : dly_settle_ctr
// Purpose  : Blanking counter that reports when a new tap selection has settled
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dly_settle_ctr #(
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [SEL_W:0]   i_load_val,
    input  logic             i_en,
    output logic             o_settled
);

    localparam int CNT_W = SEL_W + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A load takes priority over the decrement in the same cycle
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_settled = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/tapped_delay_line_prog.sv
// ============================================================================
// Module   : tapped_delay_line_prog
// Purpose  : Enable-gated tapped delay line with runtime tap select and settle blanking
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tapped_delay_line_prog
    import lpddr4_dly_pkg::*;
#(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = DLY_DEPTH_DEF,
    localparam int SEL_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_flush,
    input  logic                   i_vld,
    input  logic [WIDTH-1:0]       i_d,
    input  logic                   i_sel_load,
    input  logic [SEL_W-1:0]       i_dly_sel,
    output logic [DEPTH*WIDTH-1:0] o_taps,
    output logic [DEPTH-1:0]       o_tap_vld,
    output logic [WIDTH-1:0]       o_d,
    output logic                   o_vld,
    output logic                   o_settled,
    output logic [SEL_W-1:0]       o_sel
);

    localparam int CNT_W = SEL_W + 1;

    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_d;
    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0]            vld_d;
    logic [SEL_W-1:0]            sel_q;
    logic [SEL_W-1:0]            sel_d;
    logic [SEL_W-1:0]            w_sel_clamped;
    logic                        w_settled;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign data_d[k] = i_en ? i_d : data_q[k];
                assign vld_d[k]  = i_flush ? 1'b0 : (i_en ? i_vld : vld_q[k]);
            end else begin : g_body
                assign data_d[k] = i_en ? data_q[k-1] : data_q[k];
                assign vld_d[k]  = i_flush ? 1'b0 : (i_en ? vld_q[k-1] : vld_q[k]);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q[k] <= '0;
                    vld_q[k]  <= 1'b0;
                end else begin
                    data_q[k] <= data_d[k];
                    vld_q[k]  <= vld_d[k];
                end
            end
        end
    endgenerate

    assign w_sel_clamped = SEL_W'(dly_clamp_sel(32'(i_dly_sel), 32'(DEPTH)));

    always_comb begin
        sel_d = sel_q;
        if (i_sel_load) begin
            sel_d = w_sel_clamped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= SEL_W'(DEPTH - 1);
        end else begin
            sel_q <= sel_d;
        end
    end

    // Blanking length covers the full pipeline latency of the new tap
    dly_settle_ctr #(
        .SEL_W (SEL_W)
    ) u_settle (
        .clk        (clk),
        .rst        (rst),
        .i_load     (i_sel_load),
        .i_load_val (CNT_W'(w_sel_clamped) + CNT_W'(1)),
        .i_en       (i_en),
        .o_settled  (w_settled)
    );

    assign o_taps    = data_q;
    assign o_tap_vld = vld_q;
    assign o_d       = data_q[sel_q];
    assign o_vld     = vld_q[sel_q] & w_settled;
    assign o_settled = w_settled;
    assign o_sel     = sel_q;

endmodule

`default_nettype wire

// File: doc/tapped_delay_line_prog.md
# tapped_delay_line_prog

Parametrised, runtime-programmable tapped delay line for the LPDDR4 controller datapath. It carries a `WIDTH`-bit word plus a valid bit through `DEPTH` register stages, and exposes every tap. It also provides one output selected at runtime from register `i_dly_sel`, used for read-enable/DQS-gate alignment during training. It adds advance-enable, valid tracking, flush, and a settle counter that blanks the selected output after a delay change.

## Interface
- `WIDTH`, 1, data width per stage
- `DEPTH`, 32, number of stages (≥2); `SEL_W = $clog2(DEPTH)` is a derived localparam
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `i_en`  in  1  advance enable; the line shifts only when high
- `i_flush`  in  1  clears all stage valid bits
- `i_vld`  in  1  valid for `i_d`
- `i_d`  in  `WIDTH`  input word
- `i_sel_load`  in  1  latch `i_dly_sel` into the selection register
- `i_dly_sel`  in  `SEL_W`  tap index; selected delay = index+1 enabled cycles
- `o_taps`  out  `DEPTH*WIDTH`  all stage data; stage k at `[k*WIDTH +: WIDTH]`
- `o_tap_vld`  out  `DEPTH`  all stage valid bits
- `o_d`  out  `WIDTH`  data at selected stage
- `o_vld`  out  1  valid at selected stage AND `o_settled`
- `o_settled`  out  1  high when the settle counter is zero
- `o_sel`  out  `SEL_W`  current selection register

## Operation
- Stage 0 captures `i_d`/`i_vld`; stage k captures stage k-1. Capture happens only on edges where `i_en`=1. With `i_en`=0, all stages hold.
- `i_flush`=1: on that edge every valid bit, including the stage-0 capture, becomes 0. Data bits follow normal shift/hold behaviour. Flush acts regardless of `i_en`.
- Selection register `sel_q` loads on `i_sel_load`=1. A value greater than `DEPTH-1` (non-power-of-2 `DEPTH`) clamps to `DEPTH-1`.
- `o_d` and the pre-blanking valid are a combinational mux of stage `sel_q`. `o_taps`, `o_tap_vld` and `o_sel` are direct register outputs.
- Settle counter, width `SEL_W+1`:
  - On `i_sel_load` it loads (clamped sel)+1.
  - Otherwise it decrements on edges where `i_en`=1 and count≠0.
  - A reload while counting restarts from the new value.
  - `o_settled` = (count==0).
- Simultaneous `i_sel_load` and `i_flush`: both take effect. Simultaneous `i_sel_load` and `i_en`: the load wins, so there is no decrement that cycle.

## Timing
- Reset values:
  - all stage data and valid bits 0
  - `sel_q` = `DEPTH-1`
  - settle count 0
  - resulting outputs: `o_taps`=0, `o_tap_vld`=0, `o_d`=0, `o_vld`=0, `o_settled`=1, `o_sel`=`DEPTH-1`
- Reset asserted mid-operation overrides all other inputs on that edge.
- Latency: a word presented at an enabled edge appears on stage k after k+1 enabled edges. With `i_en` held high and `sel_q`=k, `o_d` equals `i_d` from k+1 cycles earlier.
- After `i_sel_load` of value k at edge t, with `i_en` held high, `o_settled` is low from t through t+k+1 and returns high after edge t+k+1. `o_sel` updates at edge t.
- There are no handshakes and no backpressure. The block is a pure pipeline gated by `i_en`.

## Structure
- The shared package `lpddr4_dly_pkg` holds the default-depth constant `DLY_DEPTH_DEF`=32 and a helper function that clamps a selection to `DEPTH-1`.
- The settle counter is a separate sub-module, `dly_settle_ctr`, parametrised by `SEL_W`. Its inputs are load, load value, and enable; its output is `settled`.
- Stages are a generate/for loop over a packed data array and a valid vector. This block has no other sub-modules.

## Test plan
- Reset, then `i_en`=1, `i_vld`=1, `i_d` counting 1,2,3… with `sel_q`=31. Required: `o_d`=1 with `o_vld`=1 exactly 32 cycles after the first input, and the count follows consecutively.
- Load sel=3, then stream 0xA5 with `i_en` high. Required: `o_settled` low for 4 cycles, then `o_d`=0xA5 and `o_vld`=1 four cycles after input.
- Alternate `i_en` 1/0 with sel=2. Required: a word appears after 3 enabled edges, and taps hold on disabled cycles.
- With a full valid line, pulse `i_flush` together with `i_en` and `i_vld`=1. Required: `o_tap_vld`=0 on the next cycle, and data continues shifting.
- Load sel=10, then reload sel=1 two cycles later. Required: `o_settled` goes high 2 cycles after the reload. Also drive `i_sel_load`, `i_flush` and `rst` together. Required: reset values.
- Run at `DEPTH`=20 and load `i_dly_sel`=31. Required: `o_sel`=19 and the settle count is 20.
